if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the ID stage.
- Owns the fetch PC and issues sequential word requests to instruction memory. Responses are buffered in a small in-order FIFO and presented to ID as {valid, pc, inst}.
- Accepts a redirect from EX for jal/jalr/branch. A redirect flushes buffered instructions and discards responses still in flight.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fifo.sv | 66 ++++++
 rtl/if_fetch.sv | 125 ++++++++++++
 tb/tb_if_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch top, its FIFO and the bench.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small in-order FIFO with synchronous flush.
// Used for the instruction buffer and the request tag queue.
module if_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the same cycle, so push at full is allowed then
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(DEPTH));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC, issues word requests and
// buffers responses for ID; EX redirects flush and drop in-flight work.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        valid,
    input  logic        ID_ready,
    output logic [31:0] pc,
    output logic [31:0] inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [OW-1:0] out_nxt;
    logic          run;
    logic          req_fire;
    logic          rsp_fire;
    logic          pop;
    logic          keep;
    logic [31:0]   kept;
    logic [FW-1:0] fifo_count;
    logic          fifo_empty;
    if_id_t        fifo_head;
    if_id_t        fifo_in;
    logic [31:0]   tag_head;
    logic          tag_empty;
    logic [OW-1:0] tag_count;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    assign pop      = valid & ID_ready;
    assign keep     = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
    assign out_nxt  = outstanding + OW'(req_fire) - OW'(rsp_fire);

    // Credit: every response we intend to keep already owns a FIFO slot
    assign kept = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);

    assign imem_req_valid = run
                          & (outstanding < OW'(MAX_OUTSTANDING))
                          & (kept < 32'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign valid   = ~fifo_empty;
    assign pc      = fifo_head.pc;
    assign inst    = fifo_head.inst;
    assign fifo_in = '{pc: tag_head, inst: imem_rsp_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_nxt;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                drop_cnt <= out_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
            end
        end
    end

    if_fifo #(
        .W     ($bits(if_id_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep),
        .push_data (fifo_in),
        .pop       (pop & ~redirect_valid),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    if_fifo #(
        .W     (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_fire),
        .head      (tag_head),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assert property (@(posedge clk) disable iff (!rst)
        drop_cnt <= outstanding && outstanding <= OW'(MAX_OUTSTANDING));
    assert property (@(posedge clk) disable iff (!rst)
        !(rsp_fire && outstanding == '0));
    assert property (@(posedge clk) disable iff (!rst)
        tag_count == outstanding && tag_empty == (outstanding == '0));

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed phases push expected
// {pc, inst} pairs; a monitor pops and compares on every ID handshake.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid;
    logic        ID_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] sb [$];
    logic [31:0] mq [$];
    int          budget = 0;
    int          fire_cnt = 0;
    logic        rsp_en = 1'b1;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] first_pc;
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC        (32'h8000_0000),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .valid          (valid),
        .ID_ready       (ID_ready),
        .pc             (pc),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ INST_NOP ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory: grants up to 'budget' requests, answers one cycle later in order
    always @(negedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        if (!rst) begin
            mq.delete();
            imem_req_ready = 1'b0;
        end else begin
            if (rsp_en && mq.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(mq.pop_front());
            end
            imem_req_ready = (fire_cnt < budget);
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back(imem_req_addr);
                fire_cnt++;
            end
        end
    end

    // Monitor: every accepted head must match the scoreboard head
    always @(negedge clk) begin
        #1;
        if (rst && valid && ID_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h inst %h required none",
                         pc, inst);
            end else begin
                mon_e = sb.pop_front();
                chk("out_pc", pc, mon_e[63:32]);
                chk("out_inst", inst, mon_e[31:0]);
            end
        end
    end

    task automatic expect_n(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({exp_pc, inst_of(exp_pc)});
            exp_pc += 32'd4;
        end
        budget += n;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d entries pending required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int t;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_pc = 32'h8000_0000;
        @(posedge clk);
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);

        // Streaming with ID always ready
        @(negedge clk);
        ID_ready = 1'b1;
        expect_n(6);
        drain("stream");

        // ID stalls: buffer fills, requests stop, head holds
        ID_ready = 1'b0;
        first_pc = exp_pc;
        expect_n(4);
        repeat (10) @(negedge clk);
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_head_pc", pc, first_pc);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        ID_ready = 1'b1;
        drain("stall_drain");

        // Two in flight, then redirect drops both
        rsp_en = 1'b0;
        budget += 2;
        t = 0;
        while (mq.size() < 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        chk("cap_req_valid", 32'(imem_req_valid), 32'd0);
        rsp_en = 1'b1;
        redirect(32'h8000_0100);
        exp_pc = 32'h8000_0100;
        expect_n(3);
        drain("redir_drop");
        chk("drop_cnt_zero", 32'(u_dut.drop_cnt), 32'd0);

        // Redirect coincides with a request fire and a response
        budget += 2;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        #2;
        chk("coincide_rsp", 32'(imem_rsp_valid), 32'd1);
        chk("coincide_req", 32'(imem_req_valid & imem_req_ready), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'h8000_0200;
        expect_n(2);
        drain("redir_coincide");

        // Address wrap and redirect alignment
        redirect(32'hFFFF_FFF8);
        exp_pc = 32'hFFFF_FFF8;
        expect_n(3);
        drain("wrap");
        redirect(32'h0000_0103);
        chk("align_req_valid", 32'(imem_req_valid), 32'd1);
        chk("align_req_addr", imem_req_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        expect_n(1);
        @(negedge clk);
        chk("lat_valid_n1", 32'(valid), 32'd0);
        @(negedge clk);
        chk("lat_valid_n2", 32'(valid), 32'd1);
        drain("align");

        // Asynchronous reset mid-stream with a valid head
        ID_ready = 1'b0;
        budget += 2;
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_outstanding", 32'(u_dut.outstanding), 32'd0);
        chk("arst_drop_cnt", 32'(u_dut.drop_cnt), 32'd0);
        chk("arst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        ID_ready = 1'b1;
        exp_pc = 32'h8000_0000;
        expect_n(2);
        @(posedge clk);
        #1;
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_req_addr", imem_req_addr, 32'h8000_0000);
        drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
